posit_add_stream_ctrl: RTL

POSIT_ADD_STREAM_CTRL -- requirements
Module: posit_add_stream_ctrl

---
 rtl/posit_add_stream_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/posit_add_stream_ctrl.sv
// posit_add_stream_ctrl
//
// Streaming wrapper around an external fixed-latency posit adder. Operand
// pairs arrive on a valid/ready slave port, are registered and issued to the
// adder, and the sums are collected in a first-word-fall-through result FIFO
// that feeds a valid/ready master port. A credit rule (buffered plus in-flight
// results never exceed DEPTH) keeps the FIFO from overflowing even though the
// adder itself cannot be stalled.
//
// Ports
//   aclk, aresetn              clock, asynchronous active-low reset
//   s_valid/s_ready            operand handshake
//   s_in1, s_in2, s_last       operands and end-of-batch marker
//   add_in1, add_in2,
//   add_start                  registered operands and start pulse to the adder
//   add_result, add_inf,
//   add_zero, add_done         adder outputs, LATENCY cycles after add_start
//   m_valid/m_ready            result handshake
//   m_result, m_inf, m_zero,
//   m_last                     head-of-FIFO result (zero while m_valid=0)
//   cnt_inf, cnt_zero          saturating counts of NaR / zero results written
//   busy                       any result in flight or buffered
//   seq_err                    sticky: add_done disagreed with the issue tracker

module posit_add_stream_ctrl #(
    parameter int N       = 8,
    parameter int ES      = 4,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 8
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] s_in1,
    input  logic [N-1:0] s_in2,
    input  logic         s_last,
    output logic [N-1:0] add_in1,
    output logic [N-1:0] add_in2,
    output logic         add_start,
    input  logic [N-1:0] add_result,
    input  logic         add_inf,
    input  logic         add_zero,
    input  logic         add_done,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_result,
    output logic         m_inf,
    output logic         m_zero,
    output logic         m_last,
    output logic [15:0]  cnt_inf,
    output logic [15:0]  cnt_zero,
    output logic         busy,
    output logic         seq_err
);

    localparam int AW = $clog2(DEPTH);          // FIFO address bits
    localparam int PW = AW + 1;                 // pointer bits, extra MSB for full/empty
    localparam int IW = $clog2(LATENCY + 2);    // in-flight count: tracker bits + issue stage
    localparam int CW = PW + 1;                 // credit sum width
    localparam int GW = $clog2(LATENCY + 1);    // post-reset guard counter
    localparam int EW = N + 3;                  // FIFO entry: {result, inf, zero, last}

    // Elaboration-time sanity check of the parameter set.
    if (DEPTH <= LATENCY || (DEPTH & (DEPTH - 1)) != 0 || LATENCY < 1 || ES >= N) begin : g_bad_params
        $error("posit_add_stream_ctrl: need LATENCY >= 1, DEPTH a power of two > LATENCY, ES < N");
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    logic                  accept;
    logic [N-1:0]          in1_p0;
    logic [N-1:0]          in2_p0;
    logic                  vld_p0;
    logic                  last_p0;
    logic [LATENCY-1:0]    vld_sr;
    logic [LATENCY-1:0]    last_sr;
    logic                  tap_vld;
    logic                  tap_last;
    logic [IW-1:0]         inflight_count;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         fifo_count;
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [EW-1:0]         mem [DEPTH];
    logic [EW-1:0]         head;
    logic [CW-1:0]         credit_used;
    logic [GW-1:0]         guard;
    logic                  seq_err_q;
    logic [15:0]           cnt_inf_q;
    logic [15:0]           cnt_zero_q;

    // Credit: every accepted pair owns a FIFO slot from issue until it is read,
    // so the FIFO can never be written while full. s_ready is forced low
    // while reset is asserted.
    assign credit_used = CW'(fifo_count) + CW'(inflight_count);
    assign s_ready     = aresetn && (credit_used < CW'(DEPTH));
    assign accept      = s_valid && s_ready;

    // ---- stage p0: issue register toward the adder ----
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            in1_p0  <= '0;
            in2_p0  <= '0;
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else begin
            vld_p0 <= accept;
            if (accept) begin
                in1_p0  <= s_in1;
                in2_p0  <= s_in2;
                last_p0 <= s_last;
            end
        end
    end

    assign add_in1   = in1_p0;
    assign add_in2   = in2_p0;
    assign add_start = vld_p0;

    // ---- stages p1..pLATENCY: issue tracker mirroring the adder pipeline ----
    // Entry 0 is loaded from the start pulse, so the tap lines up with the
    // cycle in which the adder raises add_done for that issue.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr[0]  <= vld_p0;
            last_sr[0] <= last_p0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    assign tap_vld  = vld_sr[LATENCY-1];
    assign tap_last = last_sr[LATENCY-1];

    // The issue stage counts as in flight so a pair accepted on the last free
    // credit is already reflected in s_ready on the following cycle.
    always_comb begin
        inflight_count = IW'(vld_p0);
        for (int i = 0; i < LATENCY; i++) begin
            inflight_count = inflight_count + IW'(vld_sr[i]);
        end
    end

    // ---- result FIFO (first-word-fall-through) ----
    assign fifo_wr    = tap_vld;
    assign fifo_rd    = m_valid && m_ready;
    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (fifo_wr) mem[wr_ptr[AW-1:0]] <= {add_result, add_inf, add_zero, tap_last};
    end

    assign head     = mem[rd_ptr[AW-1:0]];
    assign m_valid  = !fifo_empty;
    // Outputs are forced to zero when empty so stale storage never shows.
    assign m_result = m_valid ? head[EW-1:3] : '0;
    assign m_inf    = m_valid && head[2];
    assign m_zero   = m_valid && head[1];
    assign m_last   = m_valid && head[0];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_inf_q  <= '0;
            cnt_zero_q <= '0;
        end else if (fifo_wr) begin
            cnt_inf_q  <= sat_inc(cnt_inf_q, add_inf);
            cnt_zero_q <= sat_inc(cnt_zero_q, add_zero);
        end
    end

    assign cnt_inf  = cnt_inf_q;
    assign cnt_zero = cnt_zero_q;

    // ---- sequence check ----
    // The adder is not reset with us; results issued before a reset can still
    // come out afterwards. The guard masks the check for LATENCY cycles after
    // release, which is exactly the window in which such leftovers can appear.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            guard     <= GW'(LATENCY);
            seq_err_q <= 1'b0;
        end else begin
            if (guard != '0) guard <= guard - 1'b1;
            if (guard == '0 && (tap_vld != add_done)) seq_err_q <= 1'b1;
        end
    end

    assign seq_err = seq_err_q;
    assign busy    = (inflight_count != '0) || (fifo_count != '0);

    no_write_when_full : assert property (@(posedge aclk) disable iff (!aresetn) !(fifo_wr && fifo_full));

endmodule
